// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS control path: opcode and funct encodings,
// ALU operation codes, and the layout of the 23-bit registered control word.
package mips_pkg;

  localparam int CTRL_W  = 23;
  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_RTYPE = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b000110;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_MUL = 6'b110010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;

  // Bit positions inside the control word.
  localparam int BIT_REG_WRITE  = 22;
  localparam int BIT_MEM_WRITE  = 21;
  localparam int BIT_MEM_TO_REG = 20;
  localparam int BIT_ALU_SRC    = 19;
  localparam int BIT_REG_DST    = 18;
  localparam int LSB_ALU_OP     = 15;
  localparam int LSB_DEST_REG   = 10;
  localparam int LSB_SRC_A      = 5;
  localparam int LSB_SRC_B      = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_MUL = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100
  } alu_op_e;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    alu_op_e    alu_op;
    logic [4:0] dest_reg;
    logic [4:0] src_a;
    logic [4:0] src_b;
  } ctrl_t;

endpackage

// File: rtl/mips_control_if.sv
// Instruction-in / control-word-out bundle between fetch and the decoder.
//   in  : 32-bit instruction word (driven by fetch / master)
//   out : 23-bit registered control word (driven by decoder / slave)
interface mips_control_if;
  import mips_pkg::*;

  logic [INSTR_W-1:0] in;
  logic [CTRL_W-1:0]  out;

  modport master (output in, input  out);
  modport slave  (input  in, output out);
endinterface

// File: rtl/control_decode.sv
// Combinational instruction decoder.
//   instr : 32-bit instruction word
//   ctrl  : next control word; all-zero (NOP) for illegal encodings
module control_decode
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [CTRL_W-1:0]  ctrl
);

  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;
  logic [5:0] funct;
  ctrl_t      ctrl_s;
  logic       unused_shamt;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];

  // Shift amount is not part of the control word.
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    // NOTE: the all-zero default covers every path, so no latch is inferred
    // and any unmatched encoding falls out as a NOP.
    ctrl_s = '0;
    unique case (opcode)
      OP_LW: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = 1'b1;
        ctrl_s.alu_src    = 1'b1;
        ctrl_s.alu_op     = ALU_ADD;
        ctrl_s.dest_reg   = rt;
        ctrl_s.src_a      = rs;
      end
      OP_SW: begin
        ctrl_s.mem_write = 1'b1;
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.alu_op    = ALU_ADD;
        ctrl_s.src_a     = rs;
        ctrl_s.src_b     = rt;
      end
      OP_RTYPE: begin
        // Populate the R-type fields only for a recognised funct; an
        // unknown funct must leave the whole word at NOP.
        if (funct inside {FUNCT_ADD, FUNCT_SUB, FUNCT_MUL, FUNCT_AND, FUNCT_OR}) begin
          ctrl_s.reg_write = 1'b1;
          ctrl_s.reg_dst   = 1'b1;
          ctrl_s.dest_reg  = rd;
          ctrl_s.src_a     = rs;
          ctrl_s.src_b     = rt;
          unique case (funct)
            FUNCT_SUB: ctrl_s.alu_op = ALU_SUB;
            FUNCT_MUL: ctrl_s.alu_op = ALU_MUL;
            FUNCT_AND: ctrl_s.alu_op = ALU_AND;
            FUNCT_OR:  ctrl_s.alu_op = ALU_OR;
            default:   ctrl_s.alu_op = ALU_ADD;
          endcase
        end
      end
      default: ctrl_s = '0;
    endcase
  end

  assign ctrl = ctrl_s;

endmodule

// File: rtl/mips_control.sv
// MIPS main control: combinational decode followed by a 23-bit output
// register, one cycle of latency from instruction to control word.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears the control word
//   bus : slave side of mips_control_if (in = instruction, out = control)
module mips_control
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mips_control_if.slave bus
);

  logic [CTRL_W-1:0] out_d;
  logic [CTRL_W-1:0] out_q;

  control_decode u_decode (
    .instr (bus.in),
    .ctrl  (out_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_mips_control.sv
module tb_mips_control;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mips_control_if bus ();

  mips_control u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [22:0] exp_q[$];

  // Independent reference decoder written with plain bit arithmetic.
  function automatic logic [22:0] model(input logic [31:0] i);
    logic [22:0] r;
    logic [2:0]  op;
    bit          ok;
    r  = 23'd0;
    op = 3'd0;
    ok = 1'b1;
    case (i[31:26])
      6'd5: r = (23'd1 << 22) | (23'd1 << 20) | (23'd1 << 19)
              | (23'(i[20:16]) << 10) | (23'(i[25:21]) << 5);
      6'd6: r = (23'd1 << 21) | (23'd1 << 19)
              | (23'(i[25:21]) << 5) | 23'(i[20:16]);
      6'd4: begin
        case (i[5:0])
          6'h20: op = 3'd0;
          6'h22: op = 3'd1;
          6'h32: op = 3'd2;
          6'h24: op = 3'd3;
          6'h25: op = 3'd4;
          default: ok = 1'b0;
        endcase
        if (ok)
          r = (23'd1 << 22) | (23'd1 << 18) | (23'(op) << 15)
            | (23'(i[15:11]) << 10) | (23'(i[25:21]) << 5) | 23'(i[20:16]);
      end
      default: r = 23'd0;
    endcase
    return r;
  endfunction

  // Drive at negedge, push expectation, compare #1 after the next posedge.
  task automatic step(input string name, input logic [31:0] instr, input logic [22:0] exp);
    logic [22:0] e;
    @(negedge clk);
    bus.in = instr;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, out=%h", name, bus.out);
    end else begin
      e = exp_q.pop_front();
      if (bus.out !== e) begin
        errors++;
        $display("FAIL %s: in=%h out=%h expected=%h", name, instr, bus.out, e);
      end
    end
  endtask

  task automatic test_reset();
    bus.in = 32'h16E0_0C00;
    rst = 1'b1;
    #2;
    checks++;
    if (bus.out !== 23'h0) begin
      errors++;
      $display("FAIL reset_async: out=%h expected=000000", bus.out);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out !== 23'h0) begin
      errors++;
      $display("FAIL reset_hold: out=%h expected=000000", bus.out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mem();
    step("lw", 32'h16E0_0C00, 23'h5802E0);
    step("sw", 32'h1AE6_0FFF, 23'h2802E6);
  endtask

  task automatic test_rtype();
    step("r_add", 32'h1043_2AA0, 23'h441443);
    step("r_sub", 32'h1085_32A2, 23'h449885);
    step("r_mul", 32'h1001_22B2, 23'h451001);
    step("r_and", 32'h1318_C2A4, 23'h45E318);
    step("r_or",  32'h1318_C2A5, 23'h466318);
  endtask

  task automatic test_illegal();
    step("op_000000",    32'h0043_2AA0, 23'h000000);
    step("op_111111",    32'hFC43_2AA0, 23'h000000);
    step("rtype_funct0", 32'h1043_2A80, 23'h000000);
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops [6] = '{6'd4, 6'd4, 6'd5, 6'd6, 6'd0, 6'd9};
    logic [5:0]  fns [7] = '{6'h20, 6'h22, 6'h32, 6'h24, 6'h25, 6'h21, 6'h3F};
    logic [31:0] instr;
    for (int n = 0; n < 40; n++) begin
      instr = $urandom();
      instr[31:26] = ops[$urandom_range(0, 5)];
      instr[5:0]   = fns[$urandom_range(0, 6)];
      step("random", instr, model(instr));
    end
  endtask

  task automatic test_midcycle();
    step("pre_mid", 32'h1318_C2A5, 23'h466318);
    #2;
    bus.in = 32'h16E0_0C00;
    #1;
    checks++;
    if (bus.out !== 23'h466318) begin
      errors++;
      $display("FAIL mid_hold: out=%h expected=466318", bus.out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out !== 23'h5802E0) begin
      errors++;
      $display("FAIL mid_next_edge: out=%h expected=5802E0", bus.out);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out !== 23'h0) begin
      errors++;
      $display("FAIL mid_reset: out=%h expected=000000", bus.out);
    end
    @(negedge clk);
    rst = 1'b0;
    step("after_reset", 32'h1AE6_0FFF, 23'h2802E6);
  endtask

  initial begin
    test_reset();
    test_mem();
    test_rtype();
    test_illegal();
    test_back_to_back();
    test_midcycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
